// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the PCI bus arbiter.
// Holds the arbiter FSM state encoding and the owner index width.
package pci_arb_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int OWNER_W     = 3;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        BUSY,
        DEAD
    } arb_state_e;

endpackage

// File: rtl/pci_rr_picker.sv
// Circular priority encoder for the PCI bus arbiter.
// Picks the first requester above the last-served index, wrapping around.
module pci_rr_picker
    import pci_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [OWNER_W-1:0]     last,
    output logic [OWNER_W-1:0]     win,
    output logic                   any
);

    logic found;

    // Search masters above last first, then wrap to the ones at or below it.
    always_comb begin
        win   = '0;
        found = 1'b0;
        any   = |req;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (!found && req[j] && (j > int'(last))) begin
                win   = OWNER_W'(j);
                found = 1'b1;
            end
        end
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (!found && req[j] && (j <= int'(last))) begin
                win   = OWNER_W'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central round-robin PCI bus arbiter with dead-cycle handover and grant timeout.
// Bus parking on PARK_ID is enabled by defining ARB_PARK_EN.
module pci_bus_arbiter
    import pci_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 16,
    parameter int PARK_ID     = 0
) (
    input  logic                   CLK,
    input  logic                   REST,
    input  logic [NUM_MASTERS-1:0] REQ_N,
    input  logic                   FRAME,
    input  logic                   IRDY,
    output logic [NUM_MASTERS-1:0] GNT_N,
    output logic [OWNER_W-1:0]     OWNER,
    output logic                   OWNER_VALID,
    output logic                   TIMEOUT_HIT
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [OWNER_W-1:0] PARK_OWN = OWNER_W'(PARK_ID);
    localparam logic [OWNER_W-1:0] LAST_RST = OWNER_W'(NUM_MASTERS - 1);
`ifdef ARB_PARK_EN
    localparam bit PARK_EN = 1'b1;
`else
    localparam bit PARK_EN = 1'b0;
`endif

    arb_state_e state, nxt_state;
    logic [OWNER_W-1:0] last, nxt_last, nxt_owner, win;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [NUM_MASTERS-1:0] req, owner_oh, gnt_d;
    logic any, idle_q, to_d, gnt_on;
    logic bus_idle, bus_start, own_req, others_req, parked;

    assign req        = ~REQ_N;
    assign bus_idle   = FRAME & IRDY;
    assign bus_start  = idle_q & ~FRAME;
    assign owner_oh   = NUM_MASTERS'(1) << OWNER;
    assign own_req    = |(req & owner_oh);
    assign others_req = |(req & ~owner_oh);
    assign parked     = PARK_EN && (state == IDLE) && OWNER_VALID;

    pci_rr_picker #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_picker (
        .req (req),
        .last(last),
        .win (win),
        .any (any)
    );

    // Next-state, owner, counter and registered-grant decode.
    always_comb begin
        nxt_state = state;
        nxt_owner = OWNER;
        nxt_last  = last;
        nxt_cnt   = cnt;
        to_d      = 1'b0;
        unique case (state)
            IDLE: begin
                if (parked && bus_start) begin
                    nxt_state = BUSY;
                    nxt_owner = PARK_OWN;
                    nxt_last  = PARK_OWN;
                    nxt_cnt   = '0;
                end else if (any) begin
                    if (PARK_EN && (win != PARK_OWN)) begin
                        nxt_state = DEAD;
                    end else begin
                        nxt_state = GRANT;
                        nxt_owner = win;
                        nxt_cnt   = '0;
                    end
                end else if (PARK_EN) begin
                    nxt_owner = PARK_OWN;
                end
            end
            GRANT: begin
                if (bus_start) begin
                    nxt_state = BUSY;
                    nxt_last  = OWNER;
                    nxt_cnt   = '0;
                end else if (!own_req) begin
                    nxt_state = DEAD;
                end else if (bus_idle) begin
                    if (cnt == CNT_LAST) begin
                        to_d      = 1'b1;
                        nxt_last  = OWNER;
                        nxt_state = DEAD;
                    end else if (cnt != CNT_MAX) begin
                        nxt_cnt = cnt + 1'b1;
                    end
                end
            end
            BUSY: begin
                if (others_req) begin
                    nxt_state = DEAD;
                end else if (bus_idle && !own_req) begin
                    nxt_state = DEAD;
                end
            end
            DEAD: begin
                nxt_cnt = '0;
                if (any) begin
                    nxt_state = GRANT;
                    nxt_owner = win;
                end else begin
                    nxt_state = IDLE;
                    if (PARK_EN) begin
                        nxt_owner = PARK_OWN;
                    end
                end
            end
        endcase
        gnt_on = (nxt_state == GRANT) || (nxt_state == BUSY) ||
                 (PARK_EN && (nxt_state == IDLE));
        gnt_d  = gnt_on ? ~(NUM_MASTERS'(1) << nxt_owner) : '1;
    end

    // State, arbitration bookkeeping and registered bus outputs.
    always_ff @(posedge CLK or negedge REST) begin
        if (!REST) begin
            state       <= IDLE;
            last        <= LAST_RST;
            cnt         <= '0;
            idle_q      <= 1'b1;
            GNT_N       <= '1;
            OWNER       <= '0;
            OWNER_VALID <= 1'b0;
            TIMEOUT_HIT <= 1'b0;
        end else begin
            state       <= nxt_state;
            last        <= nxt_last;
            cnt         <= nxt_cnt;
            idle_q      <= bus_idle;
            GNT_N       <= gnt_d;
            OWNER       <= nxt_owner;
            OWNER_VALID <= gnt_on;
            TIMEOUT_HIT <= to_d;
        end
    end

endmodule
